// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared encodings for the bit-serial add/subtract controller:
// FSM state values and the op-select meaning.
package serial_addsub_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_bit_slice.sv
// One-bit full adder slice built from two half-adder cells and an OR
// that merges their carries.
module serial_bit_slice (
   input  logic a_bit,
   input  logic b_bit,
   input  logic c_in,
   output logic s,
   output logic c_o
);

   logic half_sum;
   logic half_carry_ab;
   logic half_carry_c;

   assign half_sum      = a_bit ^ b_bit;
   assign half_carry_ab = a_bit & b_bit;
   assign s             = half_sum ^ c_in;
   assign half_carry_c  = half_sum & c_in;
   assign c_o           = half_carry_ab | half_carry_c;

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: one full-adder slice is stepped
// LSB-first over WIDTH cycles, with valid/ready handshakes on both sides.
module serial_addsub_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             ovf,
   output logic             zero
);

   import serial_addsub_ctrl_pkg::*;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] r_next;
   logic             slice_s;
   logic             slice_c;

   serial_bit_slice u_slice (
      .a_bit (sa[0]),
      .b_bit (sb[0]),
      .c_in  (carry),
      .s     (slice_s),
      .c_o   (slice_c)
   );

   assign r_next = {slice_s, r[WIDTH-1:1]};

   // The result port is loaded only on the final slice step, so a
   // half-built sum in r never reaches the outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         carry     <= 1'b0;
         sa        <= '0;
         sb        <= '0;
         r         <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         c_out     <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  sa       <= a;
                  sb       <= (op_sub == OP_ADD) ? b : ~b;
                  carry    <= (op_sub == OP_SUB);
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               carry <= slice_c;
               sa    <= sa >> 1;
               sb    <= sb >> 1;
               r     <= r_next;
               cnt   <= cnt + CNT_W'(1);
               // Carry into the MSB is still in the flop on this step.
               if (cnt == LAST_BIT) begin
                  result    <= r_next;
                  c_out     <= slice_c;
                  ovf       <= carry ^ slice_c;
                  zero      <= (r_next == '0);
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: a model fills a scoreboard
// at issue time and a monitor compares each consumed result against it.
module tb_serial_addsub_ctrl;

   localparam int WIDTH = 8;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             c;
      logic             v;
      logic             z;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             op_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             c_out;
   logic             ovf;
   logic             zero;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .c_out     (c_out),
      .ovf       (ovf),
      .zero      (zero)
   );

   // Reference arithmetic: widened sum, overflow from operand/result signs.
   function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic sub);
      logic [WIDTH-1:0] yy;
      logic [WIDTH:0]   full;
      exp_t             e;
      yy    = sub ? ~y : y;
      full  = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, sub};
      e.res = full[WIDTH-1:0];
      e.c   = full[WIDTH];
      e.v   = (x[WIDTH-1] == yy[WIDTH-1]) && (e.res[WIDTH-1] != x[WIDTH-1]);
      e.z   = (e.res == '0);
      return e;
   endfunction

   // Scoreboard monitor: a handshake seen here completes on the next rising edge.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL sb_empty: unexpected result %h", result);
         end else begin
            e = sb_q.pop_front();
            if (result !== e.res) begin
               errors++;
               $display("[TB] FAIL sb_result: got %h expected %h", result, e.res);
            end
            checks++;
            if (c_out !== e.c) begin
               errors++;
               $display("[TB] FAIL sb_c_out: got %b expected %b", c_out, e.c);
            end
            checks++;
            if (ovf !== e.v) begin
               errors++;
               $display("[TB] FAIL sb_ovf: got %b expected %b", ovf, e.v);
            end
            checks++;
            if (zero !== e.z) begin
               errors++;
               $display("[TB] FAIL sb_zero: got %b expected %b", zero, e.z);
            end
         end
      end
   end

   task automatic send_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic sub);
      int guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      a        = x;
      b        = y;
      op_sub   = sub;
      in_valid = 1'b1;
      sb_q.push_back(model(x, y, sub));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Counts cycles from the accept edge until out_valid, noting any in_ready.
   task automatic wait_done(input logic noise, output int cycles, output logic saw_ready);
      cycles    = 0;
      saw_ready = 1'b0;
      while (!out_valid && cycles < 50) begin
         if (in_ready) saw_ready = 1'b1;
         in_valid = noise & cycles[0];
         a        = WIDTH'($urandom);
         b        = WIDTH'($urandom);
         op_sub   = 1'($urandom);
         @(posedge clk); #1;
         cycles++;
      end
      in_valid = 1'b0;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b1;
      a         = 8'hAA;
      b         = 8'h55;
      op_sub    = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, result, c_out, ovf, zero} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
         errors++;
         $display("[TB] FAIL reset_state: got rdy=%b vld=%b res=%h c=%b v=%b z=%b expected 1 0 00 0 0 0",
                  in_ready, out_valid, result, c_out, ovf, zero);
      end
      in_valid = 1'b0;
      rst      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL idle_after_reset: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_add_basic();
      int   cyc;
      logic saw;
      send_op(8'h0F, 8'h01, 1'b0);
      wait_done(1'b0, cyc, saw);
      checks++;
      if (cyc !== WIDTH) begin
         errors++;
         $display("[TB] FAIL add_latency: got %0d cycles expected %0d", cyc, WIDTH);
      end
      checks++;
      if (saw !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL add_busy_ready: got saw=%b rdy=%b expected 0 0", saw, in_ready);
      end
      consume();
   endtask

   task automatic test_flags();
      logic [WIDTH*2:0] table_ops[5] = '{{8'hFF, 8'h01, 1'b0}, {8'h7F, 8'h01, 1'b0},
                                         {8'h80, 8'h01, 1'b1}, {8'h05, 8'h07, 1'b1},
                                         {8'h00, 8'h00, 1'b1}};
      int   cyc;
      logic saw;
      for (int i = 0; i < 5; i++) begin
         send_op(table_ops[i][16:9], table_ops[i][8:1], table_ops[i][0]);
         wait_done(1'b0, cyc, saw);
         checks++;
         if (cyc !== WIDTH || saw !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flags_latency[%0d]: got %0d cycles ready=%b expected %0d 0",
                     i, cyc, saw, WIDTH);
         end
         consume();
      end
   endtask

   task automatic test_backpressure();
      int   cyc;
      logic saw;
      exp_t e;
      send_op(8'h5A, 8'h33, 1'b0);
      e = sb_q[0];
      wait_done(1'b1, cyc, saw);
      checks++;
      if (cyc !== WIDTH || saw !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_latency: got %0d cycles ready=%b expected %0d 0", cyc, saw, WIDTH);
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid;
         a        = WIDTH'($urandom);
         @(posedge clk); #1;
         checks++;
         if ({out_valid, in_ready, result, c_out, ovf, zero} !== {1'b1, 1'b0, e.res, e.c, e.v, e.z}) begin
            errors++;
            $display("[TB] FAIL bp_hold[%0d]: got vld=%b rdy=%b res=%h c=%b v=%b z=%b expected 1 0 %h %b %b %b",
                     i, out_valid, in_ready, result, c_out, ovf, zero, e.res, e.c, e.v, e.z);
         end
      end
      in_valid = 1'b0;
      consume();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_consume: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      int   cyc;
      logic saw;
      send_op(8'h03, 8'h04, 1'b0);
      wait_done(1'b0, cyc, saw);
      checks++;
      if (cyc !== WIDTH) begin
         errors++;
         $display("[TB] FAIL b2b_latency: got %0d cycles expected %0d", cyc, WIDTH);
      end
      consume();
   endtask

   task automatic test_reset_mid_op();
      int   cyc;
      logic saw;
      a        = 8'h11;
      b        = 8'h22;
      op_sub   = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({in_ready, out_valid, result, c_out, ovf, zero} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
         errors++;
         $display("[TB] FAIL midop_reset: got rdy=%b vld=%b res=%h c=%b v=%b z=%b expected 1 0 00 0 0 0",
                  in_ready, out_valid, result, c_out, ovf, zero);
      end
      saw = 1'b0;
      for (int i = 0; i < WIDTH + 2; i++) begin
         @(posedge clk); #1;
         if (out_valid) saw = 1'b1;
      end
      checks++;
      if (saw !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midop_no_partial: got out_valid=%b expected 0", saw);
      end
      send_op(8'h10, 8'h20, 1'b0);
      wait_done(1'b0, cyc, saw);
      checks++;
      if (cyc !== WIDTH) begin
         errors++;
         $display("[TB] FAIL midop_next_latency: got %0d cycles expected %0d", cyc, WIDTH);
      end
      consume();
   endtask

   initial begin
      test_reset();
      test_add_basic();
      test_flags();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_op();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (sb_q.size() !== 0) begin
         errors++;
         $display("[TB] FAIL sb_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
Bit-serial add/subtract controller for the ALU.
- Accepts two WIDTH-bit operands and an op select over a valid/ready handshake.
- Sequences one single-bit adder slice (two half-adder cells plus a carry flop) LSB-first for WIDTH cycles.
- Presents sum and flags on a held output handshake.
- Trades latency for area: one slice instead of a WIDTH-bit ripple adder.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the bit-position counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op present.
- in_ready  output  1  block can accept a new operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op_sub  input  1  0 = A+B, 1 = A-B (two's complement).
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum or difference.
- c_out  output  1  final carry out; for subtract, 1 = no borrow.
- ovf  output  1  signed overflow.
- zero  output  1  result == 0.

Behaviour:
- Reset (synchronous; highest priority, including mid-operation):
  - state = IDLE, counter = 0, carry flop = 0, shift registers = 0.
  - in_ready = 1, out_valid = 0, result = 0, c_out = 0, ovf = 0, zero = 0.
  - An operation in flight is discarded; no partial result is ever presented.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready:
    - latch a into shift reg SA;
    - latch (op_sub ? ~b : b) into SB;
    - carry flop <- op_sub;
    - counter <- 0; go to SHIFT.
  - SHIFT: in_ready = 0, out_valid = 0. Each cycle:
    - slice computes s = SA[0]^SB[0]^carry and the carry out;
    - carry flop <- carry out;
    - SA, SB shift right by one;
    - s enters result shift reg R at the MSB and R shifts right;
    - counter increments.
  - SHIFT, on the cycle with counter == WIDTH-1:
    - capture c_out = slice carry out;
    - capture ovf = carry into the MSB (current carry flop) XOR slice carry out;
    - go to DONE.
  - DONE: out_valid = 1. result, c_out and ovf are stable; zero = (result == 0), registered.
    - Hold all outputs while out_ready = 0, indefinitely.
    - On out_valid & out_ready, go to IDLE.
- in_ready and out_valid are decoded from state only, never combinationally from in_valid/out_ready.
- Latency: acceptance at edge k -> out_valid high from edge k+WIDTH.
- Throughput: one operation per WIDTH+2 cycles at best:
  - accept edge;
  - WIDTH shift edges, the last of which enters DONE;
  - one DONE/consume edge;
  - a new accept is possible only on a following IDLE cycle.
- No accept in DONE; no overlap of consume and accept.
- in_valid while busy is ignored; the producer must hold it until in_ready.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Subtract is A + ~B + 1, so 0 - 0 gives result 0 with c_out = 1.
- Counter is compared exactly against WIDTH-1, so non-power-of-two WIDTH is handled.
- Counter never wraps in normal operation: it is reset on every accept.

Decomposition:
- Shared ALU package holds:
  - state encoding constants ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2;
  - op encoding OP_ADD = 1'b0, OP_SUB = 1'b1.
- One sub-module, serial_bit_slice: combinational full adder built from two half-adder cells plus an OR for the carry. Inputs a_bit, b_bit, c_in; outputs s, c_o.
- The carry flop and all sequencing stay in serial_addsub_ctrl.

Test Plan:
- WIDTH=8, add 0x0F+0x01:
  - -> result 0x10, c_out 0, ovf 0, zero 0;
  - out_valid exactly 8 cycles after the accept edge;
  - in_ready low throughout.
- Add 0xFF+0x01 -> result 0x00, c_out 1, ovf 0, zero 1.
- Add 0x7F+0x01 -> result 0x80, ovf 1, c_out 0.
- Sub 0x80-0x01 -> result 0x7F, ovf 1, c_out 1.
- Sub 0x05-0x07 -> result 0xFE, c_out 0, ovf 0.
- Backpressure and reset:
  - out_ready held low 5 cycles in DONE -> outputs unchanged;
  - in_valid pulses during SHIFT/DONE are ignored;
  - after consume, the next op 0x03+0x04 -> 0x07;
  - rst asserted on the 3rd SHIFT cycle -> next edge in_ready 1, out_valid 0, result 0;
  - the following op 0x10+0x20 -> 0x30 correct.
